// File: rtl/ram_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-RAM command bridge.
package ram_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;   // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;   // 'R'
    localparam logic [7:0] RSP_ACK   = 8'h4B;   // 'K'

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ADDR    = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_MEM_WR  = 3'd3;
    localparam state_t ST_RD_WAIT = 3'd4;
    localparam state_t ST_TX      = 3'd5;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/bridge_tx_serializer.sv
// Emits a loaded word (or a single byte) LSB first over a valid/ready byte port.
module bridge_tx_serializer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    load,
    input  logic [8*DATA_BYTES-1:0] word,
    input  logic [2:0]              nbytes,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    done
);

    localparam int DW = 8 * DATA_BYTES;

    logic [DW-1:0] shreg;
    logic [2:0]    rem;
    logic          valid_q;

    assign tx_data  = shreg[7:0];
    assign tx_valid = valid_q;
    // Asserted in the cycle the final byte is accepted, so the parser can leave TX on that edge.
    assign done     = valid_q && tx_ready && (rem == 3'd1);

    // Load a new word, or advance to the next byte after each handshake.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shreg   <= '0;
            rem     <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg   <= word;
            rem     <= nbytes;
            valid_q <= (nbytes != 3'd0);
        end else if (valid_q && tx_ready) begin
            if (rem == 3'd1) begin
                valid_q <= 1'b0;
            end else begin
                shreg <= shreg >> 8;
            end
            rem <= rem - 3'd1;
        end
    end

endmodule

// File: rtl/ram_bridge_cmd.sv
// Byte-stream command engine: parses 'W'/'R' commands from the UART receiver,
// drives one RAM port and returns ack / read data bytes to the transmitter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a command byte; non-command bytes flag an error
// ST_ADDR    | collecting address bytes, LSB first
// ST_DATA    | collecting write data bytes, LSB first
// ST_MEM_WR  | write strobe cycle; ack byte is queued for transmit
// ST_RD_WAIT | read strobe issued, counting down the RAM read latency
// ST_TX      | response bytes being handed to the transmitter
module ram_bridge_cmd
    import ram_bridge_pkg::*;
#(
    parameter int ADDR_BYTES     = 4,
    parameter int DATA_BYTES     = 4,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [7:0]              rx_data_in,
    input  logic                    rx_valid_in,
    output logic [8*ADDR_BYTES-1:0] mem_addr_out,
    output logic [8*DATA_BYTES-1:0] mem_wdata_out,
    output logic                    mem_we_out,
    output logic                    mem_re_out,
    input  logic [8*DATA_BYTES-1:0] mem_rdata_in,
    output logic [7:0]              tx_data_out,
    output logic                    tx_valid_out,
    input  logic                    tx_ready_in,
    output logic                    busy_out,
    output logic                    err_out
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0]    ADDR_LOAD = 3'(ADDR_BYTES);
    localparam logic [2:0]    DATA_LOAD = 3'(DATA_BYTES);
    localparam logic [2:0]    LAT_LOAD  = 3'(READ_LATENCY);
    // Idle counter runs down from TIMEOUT_CYCLES-1; hitting zero on an idle cycle is the timeout.
    localparam logic [TW-1:0] TO_LOAD   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    logic          mode_rd;
    logic [2:0]    byte_cnt;
    logic [2:0]    lat_cnt;
    logic [TW-1:0] idle_cnt;
    logic [AW-1:0] addr_buf;
    logic [DW-1:0] data_buf;
    logic [AW-1:0] addr_shift;
    logic [DW-1:0] data_shift;
    logic          timeout_hit;

    logic          ser_load;
    logic [DW-1:0] ser_word;
    logic [2:0]    ser_nbytes;
    logic          ser_done;

    // New bytes enter at the top so the first byte on the wire ends up in the LSBs.
    assign addr_shift  = (addr_buf >> 8) | (AW'(rx_data_in) << (AW - 8));
    assign data_shift  = (data_buf >> 8) | (DW'(rx_data_in) << (DW - 8));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == '0);
    assign busy_out    = (state != ST_IDLE);

    // Command parser, RAM strobes, latency/timeout counters and error pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ST_IDLE;
            mode_rd       <= 1'b0;
            byte_cnt      <= '0;
            lat_cnt       <= '0;
            idle_cnt      <= '0;
            addr_buf      <= '0;
            data_buf      <= '0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            mem_we_out    <= 1'b0;
            mem_re_out    <= 1'b0;
            err_out       <= 1'b0;
            ser_load      <= 1'b0;
            ser_word      <= '0;
            ser_nbytes    <= '0;
        end else begin
            mem_we_out <= 1'b0;
            mem_re_out <= 1'b0;
            err_out    <= 1'b0;
            ser_load   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_valid_in) begin
                        if (is_cmd(rx_data_in)) begin
                            state    <= ST_ADDR;
                            mode_rd  <= (rx_data_in == CMD_READ);
                            byte_cnt <= ADDR_LOAD;
                            idle_cnt <= TO_LOAD;
                            addr_buf <= '0;
                            data_buf <= '0;
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                end

                ST_ADDR, ST_DATA: begin
                    if (rx_valid_in) begin
                        idle_cnt <= TO_LOAD;
                        byte_cnt <= byte_cnt - 3'd1;
                        if (state == ST_ADDR) begin
                            addr_buf <= addr_shift;
                            if (byte_cnt == 3'd1) begin
                                if (mode_rd) begin
                                    mem_addr_out <= addr_shift;
                                    mem_re_out   <= 1'b1;
                                    lat_cnt      <= LAT_LOAD;
                                    state        <= ST_RD_WAIT;
                                end else begin
                                    byte_cnt <= DATA_LOAD;
                                    state    <= ST_DATA;
                                end
                            end
                        end else begin
                            data_buf <= data_shift;
                            if (byte_cnt == 3'd1) begin
                                mem_addr_out  <= addr_buf;
                                mem_wdata_out <= data_shift;
                                mem_we_out    <= 1'b1;
                                state         <= ST_MEM_WR;
                            end
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        err_out  <= 1'b1;
                        addr_buf <= '0;
                        data_buf <= '0;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end

                ST_MEM_WR: begin
                    ser_load   <= 1'b1;
                    ser_word   <= DW'(RSP_ACK);
                    ser_nbytes <= 3'd1;
                    state      <= ST_TX;
                end

                ST_RD_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        ser_load   <= 1'b1;
                        ser_word   <= mem_rdata_in;
                        ser_nbytes <= DATA_LOAD;
                        state      <= ST_TX;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                ST_TX: begin
                    if (ser_done) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            // Bytes arriving while a transfer is in flight are dropped but reported.
            if (rx_valid_in && (state == ST_MEM_WR || state == ST_RD_WAIT || state == ST_TX)) begin
                err_out <= 1'b1;
            end
        end
    end

    bridge_tx_serializer #(
        .DATA_BYTES (DATA_BYTES)
    ) u_tx_ser (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (ser_load),
        .word     (ser_word),
        .nbytes   (ser_nbytes),
        .tx_data  (tx_data_out),
        .tx_valid (tx_valid_out),
        .tx_ready (tx_ready_in),
        .done     (ser_done)
    );

endmodule
